pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher_if.sv | 29 ++
 rtl/pulse_stretcher.sv | 105 ++++++++++
 tb/tb_pulse_stretcher.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_if.sv
// Event/stretched-level bundle between a pulse source and the pulse stretcher.
// The pending width follows the stretcher's MAX_PENDING; keep the two parameters equal.
interface pulse_stretcher_if #(
  parameter int MAX_PENDING = 3
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          pulse_in;
  logic          level_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output pulse_in,
    input  level_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    output level_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into HOLD_CYCLES-wide windows separated by at least
// GAP_CYCLES low cycles, queueing up to MAX_PENDING events that arrive while busy.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PENDING = 3
) (
  input  logic             clk,
  input  logic             reset,
  pulse_stretcher_if.slave bus
);
  localparam int MAX_LEN = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PW      = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] pending_reg;
  logic          overflow_reg;
  logic          last_cycle;
  logic          queue_event;

  // Events seen while a window or a non-final gap cycle is active go to the queue;
  // the final gap cycle instead hands the event straight to the next window.
  always_comb begin
    last_cycle  = (count_reg == '0);
    queue_event = bus.pulse_in &&
                  ((state_reg == HOLD) || ((state_reg == GAP) && !last_cycle));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= 1'b0;

      if (queue_event) begin
        if (pending_reg == PEND_MAX) begin
          overflow_reg <= 1'b1;
        end else begin
          pending_reg <= pending_reg + PW'(1);
        end
      end

      case (state_reg)
        IDLE: begin
          if (bus.pulse_in) begin
            state_reg <= HOLD;
            count_reg <= HOLD_LOAD;
          end
        end

        HOLD: begin
          if (last_cycle) begin
            state_reg <= GAP;
            count_reg <= GAP_LOAD;
          end else begin
            count_reg <= count_reg - CW'(1);
          end
        end

        GAP: begin
          if (!last_cycle) begin
            count_reg <= count_reg - CW'(1);
          end else if (pending_reg != '0) begin
            // A simultaneous new event replaces the one being dequeued.
            state_reg <= HOLD;
            count_reg <= HOLD_LOAD;
            if (!bus.pulse_in) begin
              pending_reg <= pending_reg - PW'(1);
            end
          end else if (bus.pulse_in) begin
            state_reg <= HOLD;
            count_reg <= HOLD_LOAD;
          end else begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
        end
      endcase
    end
  end

  assign bus.level_out = (state_reg == HOLD);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.pending   = pending_reg;
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed cycle-by-cycle check of the pulse stretcher at default parameters.
// Each step drives reset/pulse_in for one edge, then compares {level,busy,pending,overflow}.
module tb_pulse_stretcher;
  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cyc_n;

  pulse_stretcher_if #(.MAX_PENDING(3)) ps_if ();

  pulse_stretcher #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .MAX_PENDING(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ps_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {level_out, busy, pending[1:0], overflow}
  localparam logic [4:0] I = 5'b00000;
  localparam logic [4:0] H = 5'b11000;
  localparam logic [4:0] G = 5'b01000;

  task automatic step(input string tag, input logic r, input logic p, input logic [4:0] exp);
    logic [4:0] obs;
    reset          = r;
    ps_if.pulse_in = p;
    @(posedge clk);
    #1;
    cyc_n = cyc_n + 1;
    obs   = {ps_if.level_out, ps_if.busy, ps_if.pending, ps_if.overflow};
    tests = tests + 1;
    assert (obs === exp)
    else begin
      fails = fails + 1;
      $error("FAIL %s cycle %0d: observed %b required %b", tag, cyc_n, obs, exp);
    end
    $display("[TB] %s cycle %0d reset=%b pulse=%b lvl/busy/pend/ovf=%b", tag, cyc_n, r, p, obs);
  endtask

  task automatic start(input string tag);
    cyc_n = 0;
    $display("[TB] scenario %s", tag);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    cyc_n          = 0;
    reset          = 1'b1;
    ps_if.pulse_in = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with pulse_in high, then released with no events.
    start("reset_hold");
    repeat (3) step("reset_hold", 1'b1, 1'b1, I);
    repeat (4) step("reset_idle", 1'b0, 1'b0, I);

    start("single");
    step("single", 1'b0, 1'b1, H);
    repeat (3) step("single", 1'b0, 1'b0, H);
    repeat (2) step("single", 1'b0, 1'b0, G);
    repeat (2) step("single", 1'b0, 1'b0, I);

    start("queued_one");
    step("queued_one", 1'b0, 1'b1, H);
    step("queued_one", 1'b0, 1'b0, H);
    step("queued_one", 1'b0, 1'b1, 5'b11010);
    step("queued_one", 1'b0, 1'b0, 5'b11010);
    step("queued_one", 1'b0, 1'b0, 5'b01010);
    step("queued_one", 1'b0, 1'b0, 5'b01010);
    repeat (4) step("queued_one", 1'b0, 1'b0, H);
    repeat (2) step("queued_one", 1'b0, 1'b0, G);
    step("queued_one", 1'b0, 1'b0, I);

    // Continuous input: queue fills, drops flag overflow, final gap cycle cancels.
    start("saturate");
    step("saturate", 1'b0, 1'b1, H);
    step("saturate", 1'b0, 1'b1, 5'b11010);
    step("saturate", 1'b0, 1'b1, 5'b11100);
    step("saturate", 1'b0, 1'b1, 5'b11110);
    step("saturate", 1'b0, 1'b1, 5'b01111);
    step("saturate", 1'b0, 1'b1, 5'b01111);
    step("saturate", 1'b0, 1'b1, 5'b11110);
    step("saturate", 1'b0, 1'b1, 5'b11111);
    step("saturate", 1'b0, 1'b1, 5'b11111);
    step("saturate", 1'b0, 1'b1, 5'b11111);
    step("saturate", 1'b0, 1'b0, 5'b01110);
    step("saturate", 1'b0, 1'b0, 5'b01110);
    step("saturate", 1'b0, 1'b0, 5'b11100);
    step("saturate", 1'b0, 1'b0, 5'b11100);
    step("saturate_rst", 1'b1, 1'b0, I);
    repeat (2) step("saturate_rst", 1'b0, 1'b0, I);

    // Event in the final gap cycle with an empty queue chains straight into HOLD.
    start("chain");
    step("chain", 1'b0, 1'b1, H);
    repeat (3) step("chain", 1'b0, 1'b0, H);
    step("chain", 1'b0, 1'b0, G);
    step("chain", 1'b0, 1'b0, G);
    step("chain", 1'b0, 1'b1, H);
    repeat (3) step("chain", 1'b0, 1'b0, H);
    repeat (2) step("chain", 1'b0, 1'b0, G);
    step("chain", 1'b0, 1'b0, I);

    // Reset mid-window discards queued events.
    start("reset_mid");
    step("reset_mid", 1'b0, 1'b1, H);
    step("reset_mid", 1'b0, 1'b1, 5'b11010);
    step("reset_mid", 1'b0, 1'b1, 5'b11100);
    step("reset_mid", 1'b1, 1'b0, I);
    repeat (8) step("reset_mid", 1'b0, 1'b0, I);

    // First edge after reset release accepts an event.
    start("first_edge");
    step("first_edge", 1'b1, 1'b0, I);
    step("first_edge", 1'b0, 1'b1, H);
    repeat (3) step("first_edge", 1'b0, 1'b0, H);
    repeat (2) step("first_edge", 1'b0, 1'b0, G);
    step("first_edge", 1'b0, 1'b0, I);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
